// File: rtl/cpu_prefetch.sv
// rtl/cpu_prefetch.sv - instruction fetch front end with a one-entry sequential prefetch buffer
// Demand misses go straight to the bus; after each response the next word is fetched speculatively.
module cpu_prefetch #(
   parameter int ENABLE_PREFETCH = 1
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_request,
   output logic        o_ready,
   input  logic [31:0] i_address,
   output logic [31:0] o_rdata,
   output logic        o_bus_request,
   input  logic        i_bus_ready,
   output logic [31:0] o_bus_address,
   input  logic [31:0] i_bus_rdata
);

   localparam logic PF_EN = (ENABLE_PREFETCH != 0);

   typedef enum logic [1:0] {IDLE, FETCH, PREFETCH, DONE} state_t;

   state_t      state_q, state_d;
   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        bus_request_q, bus_request_d;
   logic [31:0] bus_address_q, bus_address_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_addr_q, buf_addr_d;
   logic [31:0] buf_data_q, buf_data_d;
   logic        pending_q, pending_d;
   logic [31:0] next_addr_q, next_addr_d;

   always_comb begin
      state_d       = state_q;
      ready_d       = 1'b0;
      rdata_d       = rdata_q;
      bus_request_d = bus_request_q;
      bus_address_d = bus_address_q;
      buf_valid_d   = buf_valid_q;
      buf_addr_d    = buf_addr_q;
      buf_data_d    = buf_data_q;
      pending_d     = pending_q;
      next_addr_d   = next_addr_q;
      case (state_q)
         IDLE: begin
            // Demand requests win over a pending prefetch.
            if (i_request) begin
               if (buf_valid_q && (buf_addr_q == i_address)) begin
                  rdata_d     = buf_data_q;
                  ready_d     = 1'b1;
                  next_addr_d = i_address + 32'd4;
                  pending_d   = PF_EN;
                  state_d     = DONE;
               end else begin
                  bus_address_d = i_address;
                  bus_request_d = 1'b1;
                  state_d       = FETCH;
               end
            end else if (pending_q) begin
               pending_d     = 1'b0;
               bus_address_d = next_addr_q;
               bus_request_d = 1'b1;
               state_d       = PREFETCH;
            end
         end
         FETCH: begin
            if (i_bus_ready) begin
               bus_request_d = 1'b0;
               rdata_d       = i_bus_rdata;
               ready_d       = 1'b1;
               next_addr_d   = i_address + 32'd4;
               pending_d     = PF_EN;
               state_d       = DONE;
            end
         end
         PREFETCH: begin
            if (i_bus_ready) begin
               buf_addr_d    = bus_address_q;
               buf_data_d    = i_bus_rdata;
               buf_valid_d   = 1'b1;
               bus_request_d = 1'b0;
               state_d       = IDLE;
            end
         end
         DONE: begin
            if (!i_request) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q       <= IDLE;
         ready_q       <= 1'b0;
         rdata_q       <= 32'd0;
         bus_request_q <= 1'b0;
         bus_address_q <= 32'd0;
         buf_valid_q   <= 1'b0;
         buf_addr_q    <= 32'd0;
         buf_data_q    <= 32'd0;
         pending_q     <= 1'b0;
         next_addr_q   <= 32'd0;
      end else begin
         state_q       <= state_d;
         ready_q       <= ready_d;
         rdata_q       <= rdata_d;
         bus_request_q <= bus_request_d;
         bus_address_q <= bus_address_d;
         buf_valid_q   <= buf_valid_d;
         buf_addr_q    <= buf_addr_d;
         buf_data_q    <= buf_data_d;
         pending_q     <= pending_d;
         next_addr_q   <= next_addr_d;
      end
   end

   assign o_ready       = ready_q;
   assign o_rdata       = rdata_q;
   assign o_bus_request = bus_request_q;
   assign o_bus_address = bus_address_q;

endmodule

// File: tb/tb_cpu_prefetch.sv
// tb/tb_cpu_prefetch.sv - directed self-checking bench for cpu_prefetch
// Inputs change and outputs are sampled on the falling edge.
module tb_cpu_prefetch;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        req, ready, bus_req, bus_ready;
   logic [31:0] addr, rdata, bus_addr, bus_rdata;
   logic        np_req, np_ready, np_bus_req, np_bus_ready;
   logic [31:0] np_addr, np_rdata, np_bus_addr, np_bus_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clock = ~i_clock;

   cpu_prefetch #(.ENABLE_PREFETCH(1)) u_pf (
      .i_clock(i_clock), .i_reset(i_reset),
      .i_request(req), .o_ready(ready), .i_address(addr), .o_rdata(rdata),
      .o_bus_request(bus_req), .i_bus_ready(bus_ready),
      .o_bus_address(bus_addr), .i_bus_rdata(bus_rdata)
   );

   cpu_prefetch #(.ENABLE_PREFETCH(0)) u_np (
      .i_clock(i_clock), .i_reset(i_reset),
      .i_request(np_req), .o_ready(np_ready), .i_address(np_addr), .o_rdata(np_rdata),
      .o_bus_request(np_bus_req), .i_bus_ready(np_bus_ready),
      .o_bus_address(np_bus_addr), .i_bus_rdata(np_bus_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge i_clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset = 1'b1;
      req = 0; addr = 0; bus_ready = 0; bus_rdata = 0;
      np_req = 0; np_addr = 0; np_bus_ready = 0; np_bus_rdata = 0;
      cyc(); cyc();
      check("rst_ready", 32'(ready), 0);
      check("rst_rdata", rdata, 0);
      check("rst_bus_req", 32'(bus_req), 0);
      check("rst_bus_addr", bus_addr, 0);
      i_reset = 1'b0;

      // cold miss at 0x100, bus answers on the third cycle
      req = 1; addr = 32'h100;
      cyc();
      check("cold_bus_req", 32'(bus_req), 1);
      check("cold_bus_addr", bus_addr, 32'h100);
      cyc();
      cyc();
      check("cold_wait_ready", 32'(ready), 0);
      check("cold_wait_bus_req", 32'(bus_req), 1);
      bus_ready = 1; bus_rdata = 32'hDEADBEEF;
      cyc();
      check("cold_ready", 32'(ready), 1);
      check("cold_rdata", rdata, 32'hDEADBEEF);
      check("cold_bus_drop", 32'(bus_req), 0);
      bus_ready = 0; req = 0;
      cyc();
      check("cold_ready_pulse", 32'(ready), 0);
      check("cold_rdata_held", rdata, 32'hDEADBEEF);
      cyc();
      check("pf104_bus_req", 32'(bus_req), 1);
      check("pf104_bus_addr", bus_addr, 32'h104);

      // prefetch of 0x104 completes, then a sequential hit
      bus_ready = 1; bus_rdata = 32'h12345678;
      cyc();
      check("pf104_done", 32'(bus_req), 0);
      check("pf104_no_ready", 32'(ready), 0);
      bus_ready = 0; req = 1; addr = 32'h104;
      cyc();
      check("hit_ready", 32'(ready), 1);
      check("hit_rdata", rdata, 32'h12345678);
      check("hit_no_bus", 32'(bus_req), 0);
      req = 0;
      cyc();
      check("hit_ready_pulse", 32'(ready), 0);
      cyc();
      check("pf108_bus_req", 32'(bus_req), 1);
      check("pf108_bus_addr", bus_addr, 32'h108);

      // non-sequential demand while the 0x108 prefetch is outstanding
      req = 1; addr = 32'h200;
      cyc();
      check("ns_wait_ready", 32'(ready), 0);
      check("ns_pf_kept", bus_addr, 32'h108);
      check("ns_pf_kept_req", 32'(bus_req), 1);
      bus_ready = 1; bus_rdata = 32'hAAAA0108;
      cyc();
      check("ns_pf_done", 32'(bus_req), 0);
      check("ns_pf_no_ready", 32'(ready), 0);
      bus_ready = 0;
      cyc();
      check("ns_demand_req", 32'(bus_req), 1);
      check("ns_demand_addr", bus_addr, 32'h200);
      bus_ready = 1; bus_rdata = 32'h0BADF00D;
      cyc();
      check("ns_ready", 32'(ready), 1);
      check("ns_rdata", rdata, 32'h0BADF00D);
      bus_ready = 0; req = 0;
      cyc();
      cyc();
      check("pf204_addr", bus_addr, 32'h204);
      bus_ready = 1; bus_rdata = 32'h00000204;
      cyc();
      bus_ready = 0;

      // wrap-around: miss at the top word, prefetch goes to 0
      req = 1; addr = 32'hFFFFFFFC;
      cyc();
      check("wrap_miss_addr", bus_addr, 32'hFFFFFFFC);
      bus_ready = 1; bus_rdata = 32'h11111111;
      cyc();
      check("wrap_rdata", rdata, 32'h11111111);
      bus_ready = 0; req = 0;
      cyc();
      cyc();
      check("wrap_pf_req", 32'(bus_req), 1);
      check("wrap_pf_addr", bus_addr, 32'h00000000);
      bus_ready = 1; bus_rdata = 32'h22222222;
      cyc();
      bus_ready = 0; req = 1; addr = 32'h0;
      cyc();
      check("wrap_hit_ready", 32'(ready), 1);
      check("wrap_hit_rdata", rdata, 32'h22222222);
      req = 0;
      cyc();
      cyc();
      check("pf4_addr", bus_addr, 32'h4);
      bus_ready = 1; bus_rdata = 32'h44444444;
      cyc();
      bus_ready = 0;

      // reset in the middle of a demand fetch
      req = 1; addr = 32'h104;
      cyc();
      check("rf_bus_req", 32'(bus_req), 1);
      i_reset = 1;
      cyc();
      check("rf_bus_dropped", 32'(bus_req), 0);
      check("rf_no_ready", 32'(ready), 0);
      i_reset = 0;
      cyc();
      check("rf_remiss_req", 32'(bus_req), 1);
      check("rf_remiss_addr", bus_addr, 32'h104);
      check("rf_remiss_no_ready", 32'(ready), 0);
      bus_ready = 1; bus_rdata = 32'h55555555;
      cyc();
      check("rf_ready", 32'(ready), 1);
      check("rf_rdata", rdata, 32'h55555555);
      bus_ready = 0; req = 0;
      cyc();

      // prefetch disabled: two sequential demand reads, nothing speculative
      np_req = 1; np_addr = 32'h0;
      cyc();
      check("np0_bus_req", 32'(np_bus_req), 1);
      check("np0_bus_addr", np_bus_addr, 32'h0);
      np_bus_ready = 1; np_bus_rdata = 32'h000000A0;
      cyc();
      check("np0_rdata", np_rdata, 32'h000000A0);
      np_bus_ready = 0; np_req = 0;
      cyc();
      np_bus_ready = 1; np_bus_rdata = 32'hFFFF0000;
      cyc();
      check("np_no_spec", 32'(np_bus_req), 0);
      check("np_idle_ignores_ready", 32'(np_ready), 0);
      np_bus_ready = 0;
      cyc();
      check("np_no_spec2", 32'(np_bus_req), 0);
      np_req = 1; np_addr = 32'h4;
      cyc();
      check("np4_bus_req", 32'(np_bus_req), 1);
      check("np4_bus_addr", np_bus_addr, 32'h4);
      np_bus_ready = 1; np_bus_rdata = 32'h000000A4;
      cyc();
      check("np4_ready", 32'(np_ready), 1);
      check("np4_rdata", np_rdata, 32'h000000A4);
      np_bus_ready = 0; np_req = 0;
      cyc();
      cyc();
      check("np_no_spec3", 32'(np_bus_req), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
